arb_req_tracker: RTL and testbench
==================================

Name: arb_req_tracker

Overview:
- Requester-side companion to the single-cycle fixed-priority arbiter (LSB wins, one-hot grant).
- Collects per-client request events into saturating pending counters and presents a level request vector `req_o` to the arbiter.
- Consumes the arbiter's one-hot `gnt_i`, retires one pending request per grant, and reports each serviced grant as a registered valid/id pulse.
- Detects protocol violations on the grant bus and counter overflow.

Parameters:
- N, 32, number of clients; width of request/grant vectors.
- CNT_W, 4, width of each pending counter; max pending per client = 2^CNT_W-1.
- ID_W, $clog2(N) (min 1), width of the encoded grant index.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- evt_i  input  N  per-client request event; each set bit adds one pending request this cycle.
- req_o  output  N  request vector to arbiter; bit i = (cnt[i] != 0), driven from registered state only.
- gnt_i  input  N  grant vector from arbiter; expected one-hot or zero, same-cycle response to `req_o`.
- srv_vld_o  output  1  registered pulse: a legal grant was consumed in the previous cycle.
- srv_id_o  output  ID_W  index of the client serviced; valid only when `srv_vld_o`=1.
- pend_any_o  output  1  OR of `req_o`.
- ovf_o  output  1  sticky: an event was dropped because a counter was saturated.
- err_o  output  1  sticky: illegal grant seen.
- clr_i  input  1  synchronous clear of `ovf_o` and `err_o` only; counters untouched.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - All cnt[i]=0, so `req_o`=0 and `pend_any_o`=0.
  - `srv_vld_o`=0, `srv_id_o`=0, `ovf_o`=0, `err_o`=0.
  - Reset mid-operation discards all pending requests immediately; no `srv_vld_o` pulse follows.
- Legal grant: `gnt_i` has exactly one bit k set and `req_o[k]`=1 in the same cycle.
- Illegal grant:
  - `gnt_i` has more than one bit set, or any set bit has `req_o` low.
  - Response: set `err_o` next cycle, decrement no counter, leave `srv_vld_o` low next cycle.
- Per-client counter update each cycle, with inc = `evt_i[i]` and dec = (legal grant and k == i):
  - inc & dec: cnt unchanged.
  - inc only: if cnt == max, hold and set `ovf_o`; otherwise cnt+1.
  - dec only: cnt-1. Underflow is impossible because a legal grant requires cnt != 0.
  - neither: hold.
- Latency:
  - `evt_i[i]` in cycle t with cnt=0 → `req_o[i]`=1 in cycle t+1.
  - Legal grant in cycle t → `srv_vld_o`=1 and `srv_id_o`=k in cycle t+1; cnt[k] decremented at the same edge.
  - If cnt[k] was 1 and no new event arrives, `req_o[k]` drops in t+1.
- Back-to-back: a client with cnt=c holding every grant is serviced in c consecutive cycles, with `srv_vld_o` high c consecutive cycles.
- Simultaneous events on several clients in one cycle are all counted.
- Sticky flags:
  - `ovf_o` and `err_o` set on their conditions and clear only via `clr_i` or reset.
  - If `clr_i` and a set condition occur in the same cycle, set wins.
- No combinational path from `gnt_i` or `evt_i` to any output.

Test Plan:
- Reset check (N=4, CNT_W=2): assert reset mid-stream with cnt=[2,0,3,1] → all outputs 0 asynchronously; after release, `req_o`=0 and no `srv_vld_o` pulse.
- Single request (N=4, CNT_W=2):
  - `evt_i`=4'b0100 at t → `req_o`=0100 at t+1.
  - `gnt_i`=0100 at t+1 → `srv_vld_o`=1, `srv_id_o`=2, `req_o`=0000 at t+2.
- Multi-pending with arbiter model (N=4, CNT_W=2):
  - `evt_i`=1111, then 0011 → cnt=[2,2,1,1].
  - LSB-priority model grants each cycle → `srv_id_o` sequence 0,0,1,1,2,3 on 6 consecutive cycles, then `pend_any_o`=0.
- Saturation (N=4, CNT_W=2): 4 events to client 1 with no grants → cnt[1]=3 and `ovf_o`=1 after the 4th; then 3 grants → exactly 3 `srv_vld_o` pulses with id=1.
- Simultaneous inc/dec (N=4, CNT_W=2): cnt[3]=3, `evt_i[3]`=1 with `gnt_i`=1000 in the same cycle → cnt[3] stays 3, `ovf_o` stays 0, `srv_vld_o`=1 with id=3.
- Illegal grants (N=4, CNT_W=2):
  - `gnt_i`=0011 with `req_o`=0011 → `err_o`=1, no `srv_vld_o`, counters unchanged.
  - `gnt_i`=1000 with `req_o[3]`=0 → same response.
  - `clr_i` pulse → `err_o`=0 next cycle.

Source files
------------

// File: rtl/arb_req_tracker.sv
// Requester-side tracker for a fixed-priority arbiter: per-client saturating
// pending counters feed a level request vector, and each legal grant retires one request.
module arb_req_tracker #(
    parameter int N     = 32,
    parameter int CNT_W = 4,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    evt_i,
    output logic [N-1:0]    req_o,
    input  logic [N-1:0]    gnt_i,
    output logic            srv_vld_o,
    output logic [ID_W-1:0] srv_id_o,
    output logic            pend_any_o,
    output logic            ovf_o,
    output logic            err_o,
    input  logic            clr_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    logic [CNT_W-1:0] r_cnt     [N];
    logic [CNT_W-1:0] w_cnt_nxt [N];
    logic             w_legal;
    logic             w_illegal;
    logic             w_ovf_hit;
    logic [N-1:0]     w_dec;
    logic [ID_W-1:0]  w_gnt_id;
    logic             r_srv_vld;
    logic [ID_W-1:0]  r_srv_id;
    logic             r_ovf;
    logic             r_err;

    // Request vector decoded from the registered counters only
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_o[i] = (r_cnt[i] != '0);
        end
    end

    assign pend_any_o = |req_o;
    assign srv_vld_o  = r_srv_vld;
    assign srv_id_o   = r_srv_id;
    assign ovf_o      = r_ovf;
    assign err_o      = r_err;

    // Grant legality and index encode; the OR-accumulate is exact because only one-hot grants are used
    always_comb begin
        w_legal   = is_onehot(gnt_i) && ((gnt_i & ~req_o) == '0);
        w_illegal = (gnt_i != '0) && !w_legal;
        w_dec     = w_legal ? gnt_i : '0;
        w_gnt_id  = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt_id = w_gnt_id | (gnt_i[i] ? ID_W'(i) : '0);
        end
    end

    // Per-client counter next state; a saturated increment holds and flags overflow
    always_comb begin
        w_ovf_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            case ({evt_i[i], w_dec[i]})
                2'b10: begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_ovf_hit = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end
    end

    // State registers; sticky flags give set priority over clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
            r_srv_vld <= 1'b0;
            r_srv_id  <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_srv_vld <= w_legal;
            r_srv_id  <= w_legal ? w_gnt_id : r_srv_id;
            r_ovf     <= w_ovf_hit ? 1'b1 : (clr_i ? 1'b0 : r_ovf);
            r_err     <= w_illegal ? 1'b1 : (clr_i ? 1'b0 : r_err);
        end
    end

endmodule

// File: tb/tb_arb_req_tracker.sv
// Directed bench for arb_req_tracker (N=4, CNT_W=2) with hand-computed expectations.
module tb_arb_req_tracker;

    logic       clk;
    logic       reset;
    logic [3:0] evt_i;
    logic [3:0] req_o;
    logic [3:0] gnt_i;
    logic       srv_vld_o;
    logic [1:0] srv_id_o;
    logic       pend_any_o;
    logic       ovf_o;
    logic       err_o;
    logic       clr_i;

    int checks;
    int errors;

    arb_req_tracker #(.N(4), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .evt_i      (evt_i),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .srv_vld_o  (srv_vld_o),
        .srv_id_o   (srv_id_o),
        .pend_any_o (pend_any_o),
        .ovf_o      (ovf_o),
        .err_o      (err_o),
        .clr_i      (clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_ids [6];
    logic [3:0] lsb_gnt;

    initial begin
        checks = 0;
        errors = 0;
        exp_ids = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        reset = 1'b0;
        evt_i = 4'b0000;
        gnt_i = 4'b0000;
        clr_i = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("por_req", 32'(req_o), 32'h0);
        chk("por_vld", 32'(srv_vld_o), 32'h0);
        chk("por_flags", 32'({ovf_o, err_o, pend_any_o}), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Build cnt=[3,0,3,1], then grant client 0 and overflow client 2
        evt_i = 4'b1101; tick();
        evt_i = 4'b0101; tick();
        evt_i = 4'b0101; tick();
        chk("build_req", 32'(req_o), 32'hd);
        evt_i = 4'b0100; gnt_i = 4'b0001; tick();
        evt_i = 4'b0000; gnt_i = 4'b0000;
        chk("pre_rst_vld", 32'(srv_vld_o), 32'h1);
        chk("pre_rst_ovf", 32'(ovf_o), 32'h1);
        chk("pre_rst_req", 32'(req_o), 32'hd);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(req_o), 32'h0);
        chk("mid_rst_out", 32'({srv_vld_o, srv_id_o, pend_any_o, ovf_o, err_o}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_req", 32'(req_o), 32'h0);
        chk("post_rst_vld", 32'(srv_vld_o), 32'h0);

        // Single request
        evt_i = 4'b0100; tick();
        evt_i = 4'b0000;
        chk("single_req", 32'(req_o), 32'h4);
        chk("single_vld0", 32'(srv_vld_o), 32'h0);
        gnt_i = 4'b0100; tick();
        gnt_i = 4'b0000;
        chk("single_vld", 32'(srv_vld_o), 32'h1);
        chk("single_id", 32'(srv_id_o), 32'h2);
        chk("single_req_drop", 32'(req_o), 32'h0);
        chk("single_pend", 32'(pend_any_o), 32'h0);

        // Multi-pending drained by an LSB-priority arbiter model
        evt_i = 4'b1111; tick();
        evt_i = 4'b0011; tick();
        evt_i = 4'b0000;
        chk("multi_req", 32'(req_o), 32'hf);
        for (int k = 0; k < 6; k++) begin
            lsb_gnt = req_o & (~req_o + 4'b0001);
            gnt_i = lsb_gnt;
            tick();
            chk("multi_vld", 32'(srv_vld_o), 32'h1);
            chk("multi_id", 32'(srv_id_o), 32'(exp_ids[k]));
        end
        gnt_i = 4'b0000;
        chk("multi_pend", 32'(pend_any_o), 32'h0);
        tick();
        chk("multi_vld_end", 32'(srv_vld_o), 32'h0);

        // Saturation on client 1, set-over-clear, then clear
        evt_i = 4'b0010; tick(); tick(); tick();
        chk("sat_ovf3", 32'(ovf_o), 32'h0);
        tick();
        chk("sat_ovf4", 32'(ovf_o), 32'h1);
        clr_i = 1'b1; tick();
        chk("sat_set_wins", 32'(ovf_o), 32'h1);
        evt_i = 4'b0000; tick();
        clr_i = 1'b0;
        chk("sat_clr", 32'(ovf_o), 32'h0);
        gnt_i = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_vld", 32'(srv_vld_o), 32'h1);
            chk("sat_id", 32'(srv_id_o), 32'h1);
        end
        gnt_i = 4'b0000;
        chk("sat_req_end", 32'(req_o), 32'h0);
        tick();
        chk("sat_vld_end", 32'(srv_vld_o), 32'h0);

        // Simultaneous increment and decrement on a saturated client
        evt_i = 4'b1000; tick(); tick(); tick();
        gnt_i = 4'b1000; tick();
        evt_i = 4'b0000;
        chk("incdec_vld", 32'(srv_vld_o), 32'h1);
        chk("incdec_id", 32'(srv_id_o), 32'h3);
        chk("incdec_ovf", 32'(ovf_o), 32'h0);
        tick(); tick();
        chk("incdec_req2", 32'(req_o), 32'h8);
        tick();
        gnt_i = 4'b0000;
        chk("incdec_req3", 32'(req_o), 32'h0);
        chk("incdec_vld3", 32'(srv_vld_o), 32'h1);

        // Illegal grants
        evt_i = 4'b0011; tick();
        evt_i = 4'b0000;
        gnt_i = 4'b0011; tick();
        chk("ill_multi_err", 32'(err_o), 32'h1);
        chk("ill_multi_vld", 32'(srv_vld_o), 32'h0);
        chk("ill_multi_req", 32'(req_o), 32'h3);
        gnt_i = 4'b0000; clr_i = 1'b1; tick();
        clr_i = 1'b0;
        chk("ill_clr1", 32'(err_o), 32'h0);
        gnt_i = 4'b1000; tick();
        gnt_i = 4'b0000;
        chk("ill_norq_err", 32'(err_o), 32'h1);
        chk("ill_norq_vld", 32'(srv_vld_o), 32'h0);
        chk("ill_norq_req", 32'(req_o), 32'h3);
        clr_i = 1'b1; tick();
        clr_i = 1'b0;
        chk("ill_clr2", 32'(err_o), 32'h0);
        gnt_i = 4'b0001; tick();
        chk("ill_drain0_id", 32'({srv_vld_o, srv_id_o}), 32'h4);
        chk("ill_drain0_req", 32'(req_o), 32'h2);
        gnt_i = 4'b0010; tick();
        gnt_i = 4'b0000;
        chk("ill_drain1_id", 32'({srv_vld_o, srv_id_o}), 32'h5);
        chk("ill_drain_req", 32'(req_o), 32'h0);
        chk("ill_err_final", 32'(err_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
